// File: rtl/vga_scan_out.sv
// 640x480@60 VGA scan-out: look-ahead coordinates to the renderer, then the returned colour
// is registered onto the pins in step with delayed sync/blank. Also raises a once-per-frame vblank strobe.
`timescale 1ns/1ps
module vga_scan_out #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int PIPE   = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       draw_valid,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N
);

    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic            tick_q;
    logic [9:0]      hc_q, hc_d;
    logic [9:0]      vc_q, vc_d;
    logic            hs_raw, vs_raw, blank_raw;
    logic [PIPE-1:0] hs_dly_q, vs_dly_q, blank_dly_q;
    logic            fs_q, fs_d;
    logic [7:0]      r_q, g_q, b_q;
    logic            hs_q, vs_q, bn_q;

    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end
    end

    assign blank_raw = (hc_q < H_VIS_C) && (vc_q < V_VIS_C);
    assign hs_raw    = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
    assign vs_raw    = !((vc_q >= VS_BEG) && (vc_q <= VS_END));

    // Strobe is computed a Clk early so it lands on the edge where vc becomes V_VIS,
    // and the following non-tick edge clears it, giving a one-Clk pulse.
    assign fs_d = tick_q && (hc_q == H_LAST) && (vc_q == V_VIS_L);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_q      <= 1'b0;
            hc_q        <= '0;
            vc_q        <= '0;
            hs_dly_q    <= '1;
            vs_dly_q    <= '1;
            blank_dly_q <= '0;
            fs_q        <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            bn_q        <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            fs_q   <= fs_d;
            if (tick_q) begin
                hc_q           <= hc_d;
                vc_q           <= vc_d;
                hs_dly_q[0]    <= hs_raw;
                vs_dly_q[0]    <= vs_raw;
                blank_dly_q[0] <= blank_raw;
                for (int i = 1; i < PIPE; i++) begin
                    hs_dly_q[i]    <= hs_dly_q[i-1];
                    vs_dly_q[i]    <= vs_dly_q[i-1];
                    blank_dly_q[i] <= blank_dly_q[i-1];
                end
                // Colour from upstream is only trusted inside the visible window.
                r_q  <= blank_dly_q[PIPE-1] ? pix_r : 8'h00;
                g_q  <= blank_dly_q[PIPE-1] ? pix_g : 8'h00;
                b_q  <= blank_dly_q[PIPE-1] ? pix_b : 8'h00;
                hs_q <= hs_dly_q[PIPE-1];
                vs_q <= vs_dly_q[PIPE-1];
                bn_q <= blank_dly_q[PIPE-1];
            end
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign draw_valid  = blank_raw;
    assign frame_start = fs_q;
    assign VGA_CLK     = tick_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = bn_q;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: full horizontal timing, vertical dimensions shrunk so a whole frame
// fits in a short run. A reference scan model feeds a scoreboard of expected pin values.
`timescale 1ns/1ps
module tb_vga_scan_out;

    localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48, H_TOT = 800;
    localparam int V_VIS = 12, V_FP = 2, V_SYNC = 2, V_BP = 3, V_TOT = 19;
    localparam int PIPE = 2;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] DrawX, DrawY;
    logic       draw_valid;
    logic [7:0] pix_r = 8'h00, pix_g = 8'h00, pix_b = 8'h00;
    logic       frame_start, VGA_CLK;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;

    vga_scan_out #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .PIPE(PIPE)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .DrawX(DrawX), .DrawY(DrawY), .draw_valid(draw_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .VGA_CLK(VGA_CLK),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N)
    );

    always #10 Clk = ~Clk;

    exp_t        exp_q[$];
    logic [23:0] col_q[$];
    exp_t        exp_now;
    int total = 0, bad = 0;
    int mhc, mvc, cur_x, cur_y, mode, fs_seen, periods;

    function automatic logic [23:0] colour(int x, int y);
        logic [7:0] xb, yb;
        xb = 8'(x);
        yb = 8'(y);
        if (mode == 1) return 24'hFFFFFF;
        return {xb, ~xb, yb};
    endfunction

    task automatic init_model();
        exp_t rst_e;
        rst_e = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00};
        mhc = 0;
        mvc = 0;
        periods = 0;
        exp_q.delete();
        col_q.delete();
        repeat (PIPE + 1) exp_q.push_back(rst_e);
        {pix_r, pix_g, pix_b} = (mode == 1) ? 24'hFFFFFF : 24'h000000;
    endtask

    task automatic do_reset(int n);
        Reset_n = 1'b0;
        repeat (n) @(negedge Clk);
        Reset_n = 1'b1;
        init_model();
    endtask

    // Advance to the Clk negedge just before the next pixel tick, play upstream, update the model.
    task automatic tick_step();
        int guard;
        exp_t e;
        logic [23:0] col;
        guard = 0;
        fs_seen = 0;
        do begin
            @(negedge Clk);
            if (frame_start === 1'b1) fs_seen++;
            guard++;
        end while (VGA_CLK !== 1'b1 && guard < 4);
        if (VGA_CLK !== 1'b1) begin
            total++; bad++;
            $display("FAIL tick_timeout: VGA_CLK=%b after %0d Clk, wanted 1", VGA_CLK, guard);
        end
        periods++;
        cur_x = mhc;
        cur_y = mvc;
        exp_now = exp_q.pop_front();
        col  = colour(cur_x, cur_y);
        e.hs = !(cur_x >= H_VIS + H_FP && cur_x <= H_VIS + H_FP + H_SYNC - 1);
        e.vs = !(cur_y >= V_VIS + V_FP && cur_y <= V_VIS + V_FP + V_SYNC - 1);
        e.bn = (cur_x < H_VIS) && (cur_y < V_VIS);
        e.r  = e.bn ? col[23:16] : 8'h00;
        e.g  = e.bn ? col[15:8]  : 8'h00;
        e.b  = e.bn ? col[7:0]   : 8'h00;
        exp_q.push_back(e);
        col_q.push_back(col);
        if (col_q.size() > PIPE) {pix_r, pix_g, pix_b} = col_q.pop_front();
        mhc++;
        if (mhc == H_TOT) begin
            mhc = 0;
            mvc++;
            if (mvc == V_TOT) mvc = 0;
        end
    endtask

    task automatic test_reset();
        mode = 0;
        init_model();
        Reset_n = 1'b0;
        repeat (5) @(negedge Clk);
        total++;
        if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {3'b110, 24'h0}) begin
            bad++;
            $display("FAIL reset_pins: hs/vs/bn/rgb=%b%b%b %h%h%h, wanted 110 000000",
                     VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B);
        end
        total++;
        if ({VGA_CLK, frame_start, VGA_SYNC_N} !== 3'b000) begin
            bad++;
            $display("FAIL reset_clk_fs_sync: got %b%b%b, wanted 000", VGA_CLK, frame_start, VGA_SYNC_N);
        end
        total++;
        if ({DrawX, DrawY, draw_valid} !== {20'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_draw: X=%0d Y=%0d valid=%b, wanted 0 0 1", DrawX, DrawY, draw_valid);
        end
        Reset_n = 1'b1;
        tick_step();
        total++;
        if ({DrawX, DrawY, draw_valid} !== {20'd0, 1'b1}) begin
            bad++;
            $display("FAIL first_tick_draw: X=%0d Y=%0d valid=%b, wanted 0 0 1", DrawX, DrawY, draw_valid);
        end
    endtask

    task automatic test_line_timing();
        int fall1, fall2, low_cnt;
        logic prev_hs;
        mode = 0;
        do_reset(5);
        fall1 = -1; fall2 = -1; low_cnt = 0; prev_hs = 1'b1;
        for (int p = 0; p < 1700; p++) begin
            tick_step();
            total++;
            if ({DrawX, DrawY} !== {10'(cur_x), 10'(cur_y)}) begin
                bad++;
                $display("FAIL line_draw_xy: got (%0d,%0d), wanted (%0d,%0d)", DrawX, DrawY, cur_x, cur_y);
            end
            if (prev_hs === 1'b1 && VGA_HS === 1'b0) begin
                if (fall1 < 0) fall1 = periods - 1;
                else if (fall2 < 0) fall2 = periods - 1;
            end
            if (fall1 >= 0 && fall2 < 0 && VGA_HS === 1'b0) low_cnt++;
            prev_hs = VGA_HS;
        end
        total++;
        if (fall1 != H_VIS + H_FP + PIPE + 1) begin
            bad++;
            $display("FAIL hs_first_fall: tick %0d, wanted %0d", fall1, H_VIS + H_FP + PIPE + 1);
        end
        total++;
        if (low_cnt != H_SYNC) begin
            bad++;
            $display("FAIL hs_width: %0d ticks, wanted %0d", low_cnt, H_SYNC);
        end
        total++;
        if (fall2 - fall1 != H_TOT) begin
            bad++;
            $display("FAIL hs_period: %0d ticks, wanted %0d", fall2 - fall1, H_TOT);
        end
    endtask

    task automatic test_colour();
        int x;
        mode = 0;
        do_reset(5);
        for (int p = 0; p < 810; p++) begin
            tick_step();
            total++;
            if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== exp_now) begin
                bad++;
                $display("FAIL colour_pins @tick%0d: got %b%b%b %h%h%h, wanted %h", periods,
                         VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, exp_now);
            end
            x = periods - (PIPE + 2);
            if (x >= 0 && x < 256) begin
                total++;
                if (VGA_R !== 8'(x)) begin
                    bad++;
                    $display("FAIL colour_column x=%0d: VGA_R=%0d, wanted %0d", x, VGA_R, x);
                end
            end else if (x >= H_VIS && x < H_TOT) begin
                total++;
                if (VGA_R !== 8'h00) begin
                    bad++;
                    $display("FAIL colour_hblank x=%0d: VGA_R=%h, wanted 00", x, VGA_R);
                end
            end
        end
    endtask

    task automatic test_frame();
        int vs_low, fs_total;
        mode = 1;
        do_reset(5);
        vs_low = 0; fs_total = 0;
        for (int p = 0; p < V_TOT * H_TOT; p++) begin
            tick_step();
            if (VGA_VS === 1'b0) vs_low++;
            fs_total += fs_seen;
            if (fs_seen != 0) begin
                total++;
                if (fs_seen != 1 || cur_x != 0 || cur_y != V_VIS) begin
                    bad++;
                    $display("FAIL fs_pulse: width %0d Clk at (%0d,%0d), wanted 1 at (0,%0d)",
                             fs_seen, cur_x, cur_y, V_VIS);
                end
            end
            total++;
            if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== exp_now) begin
                bad++;
                $display("FAIL frame_pins @(%0d,%0d): got %b%b%b %h%h%h, wanted %h", cur_x, cur_y,
                         VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, exp_now);
            end
            if (VGA_BLANK_N === 1'b0) begin
                total++;
                if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
                    bad++;
                    $display("FAIL blank_gate @(%0d,%0d): rgb=%h, wanted 000000", cur_x, cur_y,
                             {VGA_R, VGA_G, VGA_B});
                end
            end
        end
        total++;
        if (vs_low != V_SYNC * H_TOT) begin
            bad++;
            $display("FAIL vs_width: %0d ticks, wanted %0d", vs_low, V_SYNC * H_TOT);
        end
        total++;
        if (fs_total != 1) begin
            bad++;
            $display("FAIL fs_count: %0d Clk high per frame, wanted 1", fs_total);
        end
        tick_step();
        total++;
        if ({DrawX, DrawY} !== 20'd0) begin
            bad++;
            $display("FAIL frame_wrap: got (%0d,%0d), wanted (0,0)", DrawX, DrawY);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        mode = 0;
        do_reset(5);
        guard = 0;
        do begin
            tick_step();
            guard++;
        end while (!(cur_y == 10 && cur_x == 400) && guard < 9000);
        total++;
        if (VGA_BLANK_N !== 1'b1 || VGA_R !== 8'(400 - (PIPE + 1))) begin
            bad++;
            $display("FAIL mid_pre_reset: bn=%b r=%0d, wanted 1 %0d", VGA_BLANK_N, VGA_R, 400 - (PIPE + 1));
        end
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, VGA_CLK} !== {3'b110, 24'h0, 1'b0}) begin
            bad++;
            $display("FAIL mid_async_pins: hs/vs/bn/rgb/clk=%b%b%b %h%h%h %b, wanted 110 000000 0",
                     VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, VGA_CLK);
        end
        total++;
        if ({DrawX, DrawY, draw_valid} !== {20'd0, 1'b1}) begin
            bad++;
            $display("FAIL mid_async_draw: X=%0d Y=%0d valid=%b, wanted 0 0 1", DrawX, DrawY, draw_valid);
        end
        #17 Reset_n = 1'b1;
        init_model();
        for (int p = 0; p < 900; p++) begin
            tick_step();
            total++;
            if ({DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}
                    !== {10'(cur_x), 10'(cur_y), exp_now}) begin
                bad++;
                $display("FAIL mid_restart @tick%0d: xy=(%0d,%0d) pins=%b%b%b %h%h%h, wanted (%0d,%0d) %h",
                         periods, DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
                         cur_x, cur_y, exp_now);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_colour();
        test_frame();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
